// File: rtl/adc_fifo_scheduler.sv
// adc_fifo_scheduler
// Shares one sample FIFO between two ADC channel producers and a burst reader.
// Each FIFO access is a timed strobe (held high, then a recovery gap) because
// the FIFO edge-detects wr/rd on a slower clock. Round-robin arbitration, one
// operation in flight at a time.
module adc_fifo_scheduler #(
  parameter int DW         = 12,
  parameter int LW         = 8,
  parameter int STROBE_LEN = 4,
  parameter int STROBE_GAP = 6
) (
  input  logic          SYS_CLK,
  input  logic          reset_n,
  input  logic          ch0_valid,
  input  logic [DW-1:0] ch0_data,
  output logic          ch0_ready,
  input  logic          ch1_valid,
  input  logic [DW-1:0] ch1_data,
  output logic          ch1_ready,
  input  logic          rd_req,
  input  logic [LW-1:0] rd_len,
  input  logic          rd_abort,
  output logic          rd_busy,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          rd_ch,
  output logic          rd_done,
  output logic          fifo_wr,
  output logic [DW:0]   fifo_din,
  output logic          fifo_rd,
  input  logic [DW:0]   fifo_dout,
  input  logic          fifo_full,
  input  logic          fifo_empty
);

  localparam int CNT_MAX = (STROBE_LEN > STROBE_GAP) ? STROBE_LEN : STROBE_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(STROBE_LEN - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(STROBE_GAP - 1);

  typedef enum logic [1:0] {IDLE, PULSE, GAP, CAPTURE} state_t;
  typedef enum logic [1:0] {REQ_CH0, REQ_CH1, REQ_RD} req_t;

  state_t        state, next_state;
  req_t          rr_ptr, grant_sel, next_ptr;
  logic          active;
  logic          op_is_read;
  logic [CW-1:0] cnt;
  logic [LW-1:0] remaining;
  logic          abort_pend;
  logic [2:0]    eligible;
  logic          abort_now;
  logic          do_grant;

  // Round-robin arbiter: pick the first eligible requester starting at rr_ptr
  always_comb begin
    eligible[0] = active & ch0_valid & ~fifo_full;
    eligible[1] = active & ch1_valid & ~fifo_full;
    eligible[2] = active & rd_busy & (remaining != '0) & ~fifo_empty;
    abort_now   = (state == IDLE) & rd_busy & (rd_abort | abort_pend);
    grant_sel   = REQ_CH0;
    case (rr_ptr)
      REQ_CH1: begin
        if (eligible[1])      grant_sel = REQ_CH1;
        else if (eligible[2]) grant_sel = REQ_RD;
        else                  grant_sel = REQ_CH0;
      end
      REQ_RD: begin
        if (eligible[2])      grant_sel = REQ_RD;
        else if (eligible[0]) grant_sel = REQ_CH0;
        else                  grant_sel = REQ_CH1;
      end
      default: begin
        if (eligible[0])      grant_sel = REQ_CH0;
        else if (eligible[1]) grant_sel = REQ_CH1;
        else                  grant_sel = REQ_RD;
      end
    endcase
    case (grant_sel)
      REQ_CH0: next_ptr = REQ_CH1;
      REQ_CH1: next_ptr = REQ_RD;
      default: next_ptr = REQ_CH0;
    endcase
    do_grant = (state == IDLE) & ~abort_now & (|eligible);
  end

  // State register
  always_ff @(posedge SYS_CLK or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state: grant -> strobe -> recovery gap -> (capture for reads) -> idle
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (do_grant) next_state = PULSE;
      PULSE:   if (cnt == PULSE_LAST) next_state = GAP;
      GAP:     if (cnt == GAP_LAST) next_state = op_is_read ? CAPTURE : IDLE;
      CAPTURE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs decoded from state: ready only in the grant cycle, strobes only in PULSE
  always_comb begin
    ch0_ready = do_grant & (grant_sel == REQ_CH0);
    ch1_ready = do_grant & (grant_sel == REQ_CH1);
    fifo_wr   = (state == PULSE) & ~op_is_read;
    fifo_rd   = (state == PULSE) & op_is_read;
  end

  // Cycle counter for strobe and gap phases, restarts on every state change
  always_ff @(posedge SYS_CLK or negedge reset_n) begin
    if (!reset_n)                               cnt <= '0;
    else if (next_state != state)               cnt <= '0;
    else if (state == PULSE || state == GAP)    cnt <= cnt + CW'(1);
  end

  // Grant bookkeeping: RR pointer, operation type and the word to be written
  always_ff @(posedge SYS_CLK or negedge reset_n) begin
    if (!reset_n) begin
      active     <= 1'b0;
      rr_ptr     <= REQ_CH0;
      op_is_read <= 1'b0;
      fifo_din   <= '0;
    end else begin
      active <= 1'b1;
      if (do_grant) begin
        rr_ptr     <= next_ptr;
        op_is_read <= (grant_sel == REQ_RD);
        if (grant_sel == REQ_CH0)      fifo_din <= {1'b0, ch0_data};
        else if (grant_sel == REQ_CH1) fifo_din <= {1'b1, ch1_data};
      end
    end
  end

  // Burst tracking: start, capture of read words, completion and abort
  always_ff @(posedge SYS_CLK or negedge reset_n) begin
    if (!reset_n) begin
      rd_busy    <= 1'b0;
      remaining  <= '0;
      abort_pend <= 1'b0;
      rd_valid   <= 1'b0;
      rd_done    <= 1'b0;
      rd_data    <= '0;
      rd_ch      <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      rd_done  <= 1'b0;
      if (rd_abort && rd_busy && state != IDLE) abort_pend <= 1'b1;
      if (abort_now) begin
        rd_busy    <= 1'b0;
        remaining  <= '0;
        abort_pend <= 1'b0;
        rd_done    <= 1'b1;
      end else if (state == CAPTURE) begin
        rd_data   <= fifo_dout[DW-1:0];
        rd_ch     <= fifo_dout[DW];
        rd_valid  <= 1'b1;
        remaining <= remaining - LW'(1);
        if (remaining == LW'(1)) begin
          rd_busy    <= 1'b0;
          rd_done    <= 1'b1;
          abort_pend <= 1'b0;
        end
      end else if (rd_req && !rd_busy && rd_len != '0) begin
        rd_busy   <= 1'b1;
        remaining <= rd_len;
      end
    end
  end

endmodule
